// File: rtl/sonic_cmd_regfile.sv
// rtl/sonic_cmd_regfile.sv - command register bank with doorbell FIFO and single-outstanding issue FSM
module sonic_cmd_regfile #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1,
  parameter int PORT_NUM   = 0
) (
  input  logic        clk_in,
  input  logic        rstn,
  input  logic [7:0]  prg_addr,
  input  logic [31:0] prg_wrdata,
  input  logic        cmd_prg_wrena,
  output logic [31:0] cmd_prg_rddata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [63:0] cmd_data,
  input  logic        cmd_done,
  output logic        done_irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic               enable;
  logic               irq_en;
  logic               overflow;
  logic [31:0]        cmd_lo;
  logic [31:0]        scratch;
  logic [31:0]        done_cnt;
  logic [63:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level;

  logic [3:0]  addr;
  logic        wr_ctrl, wr_lo, push, wr_status, wr_scratch, soft_clear;
  logic        full, empty, pop, push_ok;
  logic [31:0] status, rd_mux;
  logic        unused_addr_bits;

  assign addr             = prg_addr[3:0];
  assign unused_addr_bits = ^prg_addr[7:4];

  assign wr_ctrl    = cmd_prg_wrena && (addr == 4'h0);
  assign wr_lo      = cmd_prg_wrena && (addr == 4'h1);
  assign push       = cmd_prg_wrena && (addr == 4'h2);
  assign wr_status  = cmd_prg_wrena && (addr == 4'h3);
  assign wr_scratch = cmd_prg_wrena && (addr == 4'h5);
  assign soft_clear = wr_ctrl && prg_wrdata[1];

  assign full  = (level == LEVEL_W'(FIFO_DEPTH));
  assign empty = (level == '0);

  assign cmd_valid = (state == IDLE) && enable && !empty;
  assign cmd_data  = mem[rd_ptr];
  assign pop       = cmd_valid && cmd_ready;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still fits.
  assign push_ok   = push && (!full || pop);

  always_comb begin
    status                = '0;
    status[LEVEL_W-1:0]   = level;
    status[8]             = full;
    status[9]             = empty;
    status[10]            = overflow;
    status[11]            = (state == BUSY);
    status[31:28]         = 4'(PORT_NUM);
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      4'h0:    rd_mux = {29'd0, irq_en, 1'b0, enable};
      4'h1:    rd_mux = cmd_lo;
      4'h3:    rd_mux = status;
      4'h4:    rd_mux = done_cnt;
      4'h5:    rd_mux = scratch;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      enable         <= 1'b0;
      irq_en         <= 1'b0;
      overflow       <= 1'b0;
      cmd_lo         <= '0;
      scratch        <= '0;
      done_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      done_irq       <= 1'b0;
      cmd_prg_rddata <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      cmd_prg_rddata <= rd_mux;
      done_irq       <= 1'b0;
      if (wr_ctrl) begin
        enable <= prg_wrdata[0];
        irq_en <= prg_wrdata[2];
      end
      if (wr_lo)      cmd_lo  <= prg_wrdata;
      if (wr_scratch) scratch <= prg_wrdata;
      // soft_clear overrides any push, pop or completion in the same cycle.
      if (soft_clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
        done_cnt <= '0;
        state    <= IDLE;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= {prg_wrdata, cmd_lo};
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop)      level <= level + 1'b1;
        else if (pop && !push_ok) level <= level - 1'b1;
        if (push && !push_ok)                    overflow <= 1'b1;
        else if (wr_status && prg_wrdata[10])    overflow <= 1'b0;
        case (state)
          IDLE: if (pop) state <= BUSY;
          BUSY: if (cmd_done) begin
            state    <= IDLE;
            done_cnt <= done_cnt + 32'd1;
            done_irq <= irq_en;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/sonic_cmd_regfile.md
Name: sonic_cmd_regfile

Overview:
- Command register bank behind the BAR register-access path.
- Decodes the shared programming bus (prg_addr/prg_wrdata, qualified by cmd_prg_wrena) and returns cmd_prg_rddata upstream.
- Queues 64-bit host commands in a doorbell FIFO and issues them one at a time to the port's command engine over a valid/ready handshake.
- Counts completions and raises a completion interrupt pulse.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of 2, range 2..16.
- LEVEL_W, $clog2(FIFO_DEPTH)+1: width of the FIFO occupancy counter.
- PORT_NUM, 0: port index, read back in STATUS[31:28].

Ports:
- clk_in  in  1  clock.
- rstn  in  1  reset, asynchronous active-low.
- prg_addr  in  8  register word offset; only bits [3:0] decoded, [7:4] ignored.
- prg_wrdata  in  32  write data.
- cmd_prg_wrena  in  1  write strobe for this block.
- cmd_prg_rddata  out  32  registered read data.
- cmd_valid  out  1  command available to engine.
- cmd_ready  in  1  engine accepts command.
- cmd_data  out  64  FIFO head {HI,LO}.
- cmd_done  in  1  one-cycle pulse: in-flight command finished.
- done_irq  out  1  one-cycle completion interrupt pulse.

Behaviour:
- Single clock domain, clk_in. rstn is asynchronous active-low.
- Reset values: all registers 0, FIFO empty, busy 0, cmd_valid 0, cmd_data 0, done_irq 0, cmd_prg_rddata 0.

Register map (by prg_addr[3:0]):
- 0x0 CTRL (RW): [0] enable; [1] soft_clear, write-1 self-clearing, always reads 0; [2] irq_en.
- 0x1 CMD_LO (RW): staging word.
- 0x2 CMD_HI (WO): a write pushes {prg_wrdata, CMD_LO} into the FIFO. Reads return 0.
- 0x3 STATUS:
  - [LEVEL_W-1:0] level (RO).
  - [8] full (RO).
  - [9] empty (RO).
  - [10] overflow, sticky; write 1 to clear.
  - [11] busy (RO).
  - [31:28] PORT_NUM.
- 0x4 DONE_CNT (RO): 32-bit completion count; wraps 0xFFFFFFFF->0.
- 0x5 SCRATCH (RW).
- All other offsets read 0; writes to them are ignored.

Read path:
- cmd_prg_rddata is registered from prg_addr every cycle, giving 1-cycle read latency, independent of wrena.
- A read in the cycle after a write returns the new value.

FIFO:
- Push happens on a CMD_HI write.
- Pop happens when cmd_valid && cmd_ready.
- Full with no pop in the same cycle: push dropped, overflow set, level unchanged.
- Full with a pop in the same cycle: push accepted, level unchanged.
- Simultaneous push and pop when not full: level unchanged, ordering preserved.
- Pointers wrap modulo FIFO_DEPTH.

Issue state machine:
- IDLE: cmd_valid = enable && !empty. cmd_data shows the FIFO head combinationally from the registered array. Handshake moves to BUSY and pops.
- BUSY: cmd_valid = 0. cmd_done moves to IDLE, increments DONE_CNT, and pulses done_irq next cycle if irq_en.
- cmd_done received in IDLE is ignored: no count, no irq.
- Clearing enable while in BUSY does not abort the in-flight command; only further issue is blocked.
- cmd_valid, once asserted, stays up with stable cmd_data until the handshake, except on soft_clear or enable deassertion.

soft_clear:
- Next cycle: FIFO flushed, overflow=0, busy=0, state=IDLE, DONE_CNT=0, cmd_valid=0.
- enable, irq_en, CMD_LO and SCRATCH are preserved.
- soft_clear wins over a simultaneous push, pop or cmd_done.

Reset mid-operation: asynchronous return to reset values; any in-flight command is forgotten.

Test Plan:
- Reset, then read all offsets 0x0–0xF -> all 0 except STATUS = 0x0000_0200 | PORT_NUM<<28 (empty=1). Each read arrives 1 cycle after its address.
- Write CTRL=1, CMD_LO=0xAAAA_0001, CMD_HI=0x5555_0002, with cmd_ready held 1 -> cmd_valid for 1 cycle with cmd_data=0x5555_0002_AAAA_0001. STATUS busy=1. Pulse cmd_done -> DONE_CNT=1, busy=0.
- enable=0, push 5 commands with FIFO_DEPTH=4 -> level=4, full=1, overflow=1. Write STATUS=0x400 -> overflow=0. Set enable, cmd_ready=1, pulse cmd_done after each -> exactly the first 4 commands issued in order, DONE_CNT=4.
- FIFO full, CMD_HI write in the same cycle as a pop -> push accepted, level stays 4, no overflow.
- irq_en=1, DONE_CNT preset by 0xFFFFFFFF completions (or forced) -> next cmd_done gives DONE_CNT=0 and a done_irq pulse exactly 1 cycle wide. With irq_en=0 -> no pulse.
- Three queued commands, one in BUSY, write CTRL=0x3 -> level=0, busy=0, DONE_CNT=0, cmd_valid=0, CTRL reads 0x1. Assert rstn low mid-BUSY -> all outputs 0 immediately.
